// File: rtl/sar_pkg.sv
// Shared types and default parameters for the FRIDA SAR controller.
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        EVAL,
        RECOVER,
        DONE
    } sar_state_e;

    localparam int unsigned NBITS_DEFAULT     = 8;
    localparam int unsigned T_SAMPLE_DEFAULT  = 4;
    localparam int unsigned T_TIMEOUT_DEFAULT = 16;

    // Cycles the comparator pair needs to travel through the synchronizer
    // before it reflects the current comp_clk phase.
    localparam int unsigned SYNC_SETTLE = 2;

endpackage

// File: rtl/sar_sync2.sv
// Two-flop synchronizer for asynchronous comparator decision lines.
module sar_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/sar_ctrl.sv
// SAR conversion sequencer: samples, clocks the comparator, and resolves the
// DAC trial code MSB-first, reporting the result with a one-cycle done pulse.
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned NBITS     = NBITS_DEFAULT,
    parameter int unsigned T_SAMPLE  = T_SAMPLE_DEFAULT,
    parameter int unsigned T_TIMEOUT = T_TIMEOUT_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             comp_p_i,
    input  logic             comp_n_i,
    output logic             comp_clk_o,
    output logic             sample_o,
    output logic [NBITS-1:0] dac_p_o,
    output logic [NBITS-1:0] dac_n_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [NBITS-1:0] data_o,
    output logic             meta_o
);

    localparam int unsigned CNT_MAX = (T_TIMEOUT > T_SAMPLE) ? T_TIMEOUT : T_SAMPLE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_TIMEOUT    = CNT_W'(T_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SAMPLE_END = CNT_W'(T_SAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_SETTLE     = CNT_W'(SYNC_SETTLE);

    sar_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0] code_q, code_d;
    logic [NBITS-1:0] trial_q, trial_d;
    logic             meta_r_q, meta_r_d;
    logic             comp_clk_q, comp_clk_d;
    logic             sample_q, sample_d;
    logic [NBITS-1:0] dac_p_q, dac_p_d;
    logic [NBITS-1:0] dac_n_q;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [NBITS-1:0] data_q, data_d;
    logic             meta_q, meta_d;

    logic [1:0] comp_sync;
    logic       sp, sn;
    logic       settled, timed_out, resolved, reset_seen;

    sar_sync2 #(
        .WIDTH(2)
    ) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   ({comp_p_i, comp_n_i}),
        .q_o   (comp_sync)
    );

    assign sp = comp_sync[1];
    assign sn = comp_sync[0];

    // The pair is trusted only once it reflects the present comp_clk phase.
    assign settled    = (cnt_q >= CNT_SETTLE);
    assign timed_out  = (cnt_q == CNT_TIMEOUT);
    assign resolved   = settled && (sp ^ sn);
    assign reset_seen = settled && !sp && !sn;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        code_d   = code_q;
        trial_d  = trial_q;
        meta_r_d = meta_r_q;
        data_d   = data_q;
        meta_d   = meta_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    state_d             = SAMPLE;
                    code_d              = '0;
                    trial_d             = '0;
                    trial_d[NBITS-1]    = 1'b1;
                    meta_r_d            = 1'b0;
                end
            end
            SAMPLE: begin
                if (cnt_q == CNT_SAMPLE_END) begin
                    state_d = EVAL;
                    cnt_d   = '0;
                end
            end
            EVAL: begin
                if (resolved) begin
                    state_d = RECOVER;
                    cnt_d   = '0;
                    if (sp) begin
                        code_d = code_q | trial_q;
                    end
                end else if (timed_out) begin
                    state_d  = RECOVER;
                    cnt_d    = '0;
                    meta_r_d = 1'b1;
                end
            end
            RECOVER: begin
                if (reset_seen || timed_out) begin
                    cnt_d = '0;
                    if (!reset_seen) begin
                        meta_r_d = 1'b1;
                    end
                    if (trial_q[0]) begin
                        state_d = DONE;
                        data_d  = code_q;
                        meta_d  = meta_r_d;
                        done_d  = 1'b1;
                    end else begin
                        state_d = EVAL;
                        trial_d = trial_q >> 1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                code_d  = '0;
                trial_d = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d     = (state_d != IDLE);
        sample_d   = (state_d == SAMPLE);
        comp_clk_d = (state_d == EVAL);
        dac_p_d    = (state_d inside {SAMPLE, EVAL, RECOVER}) ? (code_d | trial_d) : code_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            code_q     <= '0;
            trial_q    <= '0;
            meta_r_q   <= 1'b0;
            comp_clk_q <= 1'b0;
            sample_q   <= 1'b0;
            dac_p_q    <= '0;
            dac_n_q    <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_q     <= '0;
            meta_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            trial_q    <= trial_d;
            meta_r_q   <= meta_r_d;
            comp_clk_q <= comp_clk_d;
            sample_q   <= sample_d;
            dac_p_q    <= dac_p_d;
            dac_n_q    <= ~dac_p_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            data_q     <= data_d;
            meta_q     <= meta_d;
        end
    end

    assign comp_clk_o = comp_clk_q;
    assign sample_o   = sample_q;
    assign dac_p_o    = dac_p_q;
    assign dac_n_o    = dac_n_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign data_o     = data_q;
    assign meta_o     = meta_q;

endmodule
